// File: rtl/pkt_asm_pkg.sv
// Shared types and constants for the packet assembler: FSM states and the ACK/NAK/sync byte codes.
package pkt_asm_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] ACK_BYTE     = 8'h06;
  localparam logic [7:0] NAK_BYTE     = 8'h15;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

endpackage

// File: rtl/pkt_timeout_ctr.sv
// Inter-byte watchdog: counts enabled cycles, expire is a combinational 1-cycle pulse at TIMEOUT_CYCLES-1.
// A clear in the same cycle as the terminal count suppresses expire, so an arriving byte always wins.
module pkt_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  assign expire = en && !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pkt_assembler.sv
// Sync-hunting frame assembler: SYNC, PAYLOAD_BYTES bytes MSB-first, XOR checksum; result pulses 1 cycle after the checksum byte.
// No backpressure on rx; optional ACK/NAK byte output (PKT_ASSEMBLER_ACK_EN) holds until tx_ready, newest result overwrites.
module pkt_assembler
  import pkt_asm_pkg::*;
#(
  parameter int         PAYLOAD_BYTES  = 9,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_err,
`ifdef PKT_ASSEMBLER_ACK_EN
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
`endif
  output logic                       pkt_valid,
  output logic [PAYLOAD_BYTES*8-1:0] payload,
  output logic                       crc_err,
  output logic                       timeout_err,
  output logic                       busy
);

  localparam int PW = PAYLOAD_BYTES * 8;
  localparam int CW = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_BYTES - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   byte_cnt;
  logic [7:0]      chk;
  logic [PW-1:0]   shreg;

  logic rx_byte;
  logic start, shift, good, bad, tout;
  logic expire;

  // A byte coinciding with a line error is discarded.
  assign rx_byte = rx_valid && !rx_err;
  assign busy    = (state != HUNT);

  pkt_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .en    (state != HUNT),
    .clear (rx_valid || (state == HUNT)),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift     = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    tout      = 1'b0;
    case (state)
      HUNT: begin
        if (rx_byte && (rx_data == SYNC_BYTE)) begin
          state_nxt = DATA;
          start     = 1'b1;
        end
      end
      DATA: begin
        if (rx_err) begin
          state_nxt = HUNT;
        end else if (rx_byte) begin
          shift = 1'b1;
          if (byte_cnt == LAST_IDX) state_nxt = CHECK;
        end else if (expire) begin
          state_nxt = HUNT;
          tout      = 1'b1;
        end
      end
      CHECK: begin
        if (rx_err) begin
          state_nxt = HUNT;
        end else if (rx_byte) begin
          state_nxt = HUNT;
          good      = (rx_data == chk);
          bad       = (rx_data != chk);
        end else if (expire) begin
          state_nxt = HUNT;
          tout      = 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt    <= '0;
      chk         <= '0;
      shreg       <= '0;
      payload     <= '0;
      pkt_valid   <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pkt_valid   <= good;
      crc_err     <= bad;
      timeout_err <= tout;
      if (start) begin
        byte_cnt <= '0;
        chk      <= '0;
      end else if (shift) begin
        shreg    <= {shreg[PW-9:0], rx_data};
        chk      <= chk ^ rx_data;
        byte_cnt <= byte_cnt + CW'(1);
      end
      if (good) payload <= shreg;
    end
  end

`ifdef PKT_ASSEMBLER_ACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (good) begin
      tx_valid <= 1'b1;
      tx_data  <= ACK_BYTE;
    end else if (bad || tout) begin
      tx_valid <= 1'b1;
      tx_data  <= NAK_BYTE;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_assembler.sv
// Directed bench for pkt_assembler (TIMEOUT_CYCLES=100); inputs change on negedge, outputs checked on negedge.
module tb_pkt_assembler;

  localparam logic [71:0] P1 = 72'h010203040506070809;
  localparam logic [71:0] P2 = 72'h102030405060708090;
  localparam logic [7:0]  C1 = 8'h01;
  localparam logic [7:0]  C2 = 8'h10;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic        pkt_valid;
  logic [71:0] payload;
  logic        crc_err;
  logic        timeout_err;
  logic        busy;
`ifdef PKT_ASSEMBLER_ACK_EN
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
`endif

  int tests = 0;
  int fails = 0;
  int pv_cnt = 0;
  int pv_base;

  pkt_assembler #(
    .PAYLOAD_BYTES (9),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
`ifdef PKT_ASSEMBLER_ACK_EN
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
`endif
    .pkt_valid  (pkt_valid),
    .payload    (payload),
    .crc_err    (crc_err),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (pkt_valid) pv_cnt++;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_body(input logic [71:0] p);
    send(8'hA5);
    for (int i = 0; i < 9; i++) send(p[71-8*i -: 8]);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_err   = 1'b0;
`ifdef PKT_ASSEMBLER_ACK_EN
    tx_ready = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_pkt_valid", 72'(pkt_valid), 72'd0);
    chk("rst_payload", payload, 72'd0);
    chk("rst_crc_err", 72'(crc_err), 72'd0);
    chk("rst_timeout_err", 72'(timeout_err), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good frame
    send(8'hA5);
    chk("good_busy_after_sync", 72'(busy), 72'd1);
    for (int i = 0; i < 9; i++) send(P1[71-8*i -: 8]);
    send(C1);
    chk("good_pkt_valid", 72'(pkt_valid), 72'd1);
    chk("good_payload", payload, P1);
    chk("good_no_crc_err", 72'(crc_err), 72'd0);
    chk("good_busy_done", 72'(busy), 72'd0);
    @(negedge clk);
    chk("good_pulse_1cycle", 72'(pkt_valid), 72'd0);
    chk("good_pulse_count", 72'(pv_cnt), 72'd1);

    // Bad checksum keeps previous payload
    send_body(P2);
    send(8'h00);
    chk("bad_crc_err", 72'(crc_err), 72'd1);
    chk("bad_no_pkt_valid", 72'(pkt_valid), 72'd0);
    chk("bad_payload_kept", payload, P1);
`ifdef PKT_ASSEMBLER_ACK_EN
    chk("bad_nak", 72'(tx_data), 72'h15);
`endif
    @(negedge clk);
    chk("bad_crc_pulse_1cycle", 72'(crc_err), 72'd0);
    send_body(P2);
    send(C2);
    chk("after_bad_pkt_valid", 72'(pkt_valid), 72'd1);
    chk("after_bad_payload", payload, P2);

    // Junk before sync
    @(negedge clk);
    pv_base = pv_cnt;
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    chk("junk_busy", 72'(busy), 72'd0);
    send_body(P1);
    send(C1);
    chk("junk_payload", payload, P1);
    @(negedge clk);
    chk("junk_one_pulse", 72'(pv_cnt - pv_base), 72'd1);

    // Inter-byte timeout: 02 sampled at edge P0, expiry decided at P100
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    repeat (99) @(negedge clk);
    chk("tout_not_yet", 72'(timeout_err), 72'd0);
    chk("tout_busy_before", 72'(busy), 72'd1);
    @(negedge clk);
    chk("tout_pulse", 72'(timeout_err), 72'd1);
    chk("tout_busy_after", 72'(busy), 72'd0);
    @(negedge clk);
    chk("tout_pulse_1cycle", 72'(timeout_err), 72'd0);
    send_body(P2);
    send(C2);
    chk("after_tout_pkt_valid", 72'(pkt_valid), 72'd1);
    chk("after_tout_payload", payload, P2);

    // Reset mid-frame
    send(8'hA5);
    for (int i = 0; i < 4; i++) send(P1[71-8*i -: 8]);
    rst = 1'b1;
    #1;
    chk("midrst_payload", payload, 72'd0);
    chk("midrst_busy", 72'(busy), 72'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // rx_err mid-frame aborts; tail bytes are hunted over
    pv_base = pv_cnt;
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    rx_err = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    chk("rxerr_busy", 72'(busy), 72'd0);
    for (int i = 3; i < 9; i++) send(P1[71-8*i -: 8]);
    send(C1);
    @(negedge clk);
    chk("rxerr_no_pulse", 72'(pv_cnt - pv_base), 72'd0);
    chk("rxerr_payload_kept", payload, 72'd0);

    // Byte and rx_err together: error wins
    send(8'hA5);
    rx_err = 1'b1;
    send(8'h01);
    rx_err = 1'b0;
    chk("rxerr_with_byte_busy", 72'(busy), 72'd0);
    send_body(P1);
    send(C1);
    chk("after_rxerr_payload", payload, P1);

    // Back-to-back frames
    @(negedge clk);
    pv_base = pv_cnt;
    send_body(P2);
    send(C2);
    chk("b2b_first_pulse", 72'(pkt_valid), 72'd1);
    chk("b2b_first_payload", payload, P2);
    send(8'hA5);
    chk("b2b_low_between", 72'(pkt_valid), 72'd0);
    for (int i = 0; i < 9; i++) send(P1[71-8*i -: 8]);
    send(C1);
    chk("b2b_second_pulse", 72'(pkt_valid), 72'd1);
    chk("b2b_second_payload", payload, P1);
    @(negedge clk);
    chk("b2b_pulse_count", 72'(pv_cnt - pv_base), 72'd2);
`ifdef PKT_ASSEMBLER_ACK_EN
    chk("b2b_tx_valid", 72'(tx_valid), 72'd1);
    chk("b2b_ack_latest", 72'(tx_data), 72'h06);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
